// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity arbiter: FSM encoding, word width,
// ID width derivation and the round-robin pick.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int DATA_W  = 32;
  localparam int MAX_REQ = 16;

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [3:0]         ptr,
                                         input int                 num_req);
    logic [MAX_REQ-1:0] rot;
    logic [4:0]         idx;
    logic [3:0]         pick_rot;
    logic [4:0]         sum;
    rot      = '0;
    pick_rot = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = 5'(ptr) + 5'(i);
      if (idx >= 5'(num_req)) idx = idx - 5'(num_req);
      if (i < num_req) rot[i] = valid[idx[3:0]];
    end
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pick_rot = 4'(i);
    end
    sum = 5'(pick_rot) + 5'(ptr);
    if (sum >= 5'(num_req)) sum = sum - 5'(num_req);
    return sum[3:0];
  endfunction

endpackage

// File: rtl/parity_32.sv
// Single shared 32-bit XOR-reduction parity unit.
module parity_32 import parity_pkg::*; (
  input  logic [DATA_W-1:0] i_data,
  output logic              o_parity
);

  assign o_parity = ^i_data;

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one parity_32 unit among NUM_REQ packet streams;
// one registered response per packet carrying parity, requester ID and word count.
module parity_arbiter import parity_pkg::*; #(
  parameter  int NUM_REQ = 4,
  parameter  int ODD     = 0,
  parameter  int CNT_W   = 8,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_parity,
  output logic [ID_W-1:0]           rsp_id,
  output logic [CNT_W-1:0]          rsp_count
);

  state_e            r_state;
  state_e            w_state_next;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_grant;
  logic [ID_W-1:0]   w_pick;
  logic [ID_W-1:0]   w_grant_inc;
  logic              r_acc;
  logic              w_acc_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              r_rsp_parity;
  logic [ID_W-1:0]   r_rsp_id;
  logic [CNT_W-1:0]  r_rsp_count;
  logic [DATA_W-1:0] w_word;
  logic              w_word_par;
  logic              w_fire;
  logic              w_last;

  assign w_word = req_data[DATA_W*r_grant +: DATA_W];

  parity_32 u_parity (
    .i_data   (w_word),
    .o_parity (w_word_par)
  );

  assign w_fire      = (r_state == BURST) && req_valid[r_grant];
  assign w_last      = req_last[r_grant];
  assign w_acc_next  = r_acc ^ w_word_par;
  assign w_cnt_next  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_grant_inc = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
  assign w_pick      = ID_W'(rr_pick(MAX_REQ'(req_valid), 4'(r_ptr), NUM_REQ));

  // Outputs decode registered state only, so rsp_ready never reaches req_ready.
  assign req_ready  = (r_state == BURST) ? (NUM_REQ'(1) << r_grant) : '0;
  assign rsp_valid  = (r_state == RESP);
  assign rsp_parity = r_rsp_parity;
  assign rsp_id     = r_rsp_id;
  assign rsp_count  = r_rsp_count;

  // NOTE: next state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (|req_valid)        w_state_next = BURST;
      BURST:   if (w_fire && w_last)  w_state_next = RESP;
      RESP:    if (rsp_ready)         w_state_next = IDLE;
      default:                        w_state_next = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_grant      <= '0;
      r_acc        <= 1'b0;
      r_cnt        <= '0;
      r_rsp_parity <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_count  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_grant <= w_pick;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        BURST: begin
          if (w_fire) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            if (w_last) begin
              r_rsp_parity <= w_acc_next ^ 1'(ODD);
              r_rsp_id     <= r_grant;
              r_rsp_count  <= w_cnt_next;
            end
          end
        end
        RESP: begin
          if (rsp_ready) r_ptr <= w_grant_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_arbiter.sv
// Bench for parity_arbiter: an even/8-bit-count instance and an odd/2-bit-count
// instance share stimulus and are compared each cycle against a packet-level model.
module tb_parity_arbiter;

  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_last;
  logic [32*NREQ-1:0]   req_data;
  logic                 rsp_ready;

  logic [NREQ-1:0]      e_ready, o_ready;
  logic                 e_valid, o_valid, e_par, o_par;
  logic [1:0]           e_id, o_id;
  logic [7:0]           e_cnt;
  logic [1:0]           o_cnt;

  always #5 clk = ~clk;

  parity_arbiter #(.NUM_REQ(NREQ), .ODD(0), .CNT_W(8)) u_dut_even (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(e_ready), .rsp_valid(e_valid),
    .rsp_ready(rsp_ready), .rsp_parity(e_par), .rsp_id(e_id), .rsp_count(e_cnt)
  );

  parity_arbiter #(.NUM_REQ(NREQ), .ODD(1), .CNT_W(2)) u_dut_odd (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(o_ready), .rsp_valid(o_valid),
    .rsp_ready(rsp_ready), .rsp_parity(o_par), .rsp_id(o_id), .rsp_count(o_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Per-requester word streams: data, last flag, idle cycles before presenting.
  logic [31:0] q_data[NREQ][$];
  bit          q_last[NREQ][$];
  int          q_gap [NREQ][$];

  // Packet-level reference: 0 waiting, 1 collecting words, 2 holding a result.
  int          m_phase;
  int          m_ptr;
  int          m_grant;
  int          m_resp_cycles;
  logic [31:0] m_pkt[$];
  logic        exp_par;
  int          exp_cnt;
  int          id_log[$];
  int          rsp_mode;

  function automatic int rr_model(input logic [NREQ-1:0] v, input int ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic pkt_parity();
    int ones = 0;
    foreach (m_pkt[k]) ones += $countones(m_pkt[k]);
    return logic'(ones % 2);
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (q_data[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_grant = 0; m_resp_cycles = 0;
    m_pkt.delete();
    id_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      q_data[i].delete(); q_last[i].delete(); q_gap[i].delete();
    end
  endtask

  task automatic add_word(input int r, input logic [31:0] d, input bit last, input int gap);
    q_data[r].push_back(d);
    q_last[r].push_back(last);
    q_gap[r].push_back(gap);
  endtask

  task automatic apply_inputs();
    req_valid = '0;
    req_last  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_data[32*i +: 32] = $urandom;
      if (q_data[i].size() != 0) begin
        if (q_gap[i][0] > 0) begin
          q_gap[i][0] = q_gap[i][0] - 1;
        end else begin
          req_valid[i]         = 1'b1;
          req_data[32*i +: 32] = q_data[i][0];
          req_last[i]          = q_last[i][0];
        end
      end
    end
    case (rsp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(0, 99) < 70);
      default: rsp_ready = (m_phase == 2) && (m_resp_cycles >= 5);
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Advances cycle by cycle until the queued traffic drains (or stop_words words
  // of the current packet are in), comparing both instances against the model.
  task automatic run_traffic(input int budget, input int stop_words);
    int               cyc = 0;
    int               fire_id;
    logic [NREQ-1:0]  exp_ready;
    logic [7:0]       exp_e_cnt;
    logic [1:0]       exp_o_cnt;
    apply_inputs();
    forever begin
      if (stop_words > 0 && m_phase == 1 && m_pkt.size() == stop_words) return;
      if (m_phase == 0 && all_empty()) return;
      if (cyc >= budget) begin
        tests++; fails++;
        $display("FAIL timeout: %0d cycles without draining traffic (phase %0d)", cyc, m_phase);
        return;
      end
      exp_ready = (m_phase == 1) ? NREQ'(1 << m_grant) : '0;
      tests++;
      if (e_ready !== exp_ready || o_ready !== exp_ready) begin
        fails++;
        $display("FAIL req_ready @%0t: even=%b odd=%b expected=%b", $time, e_ready, o_ready, exp_ready);
      end
      tests++;
      if (e_valid !== (m_phase == 2) || o_valid !== (m_phase == 2)) begin
        fails++;
        $display("FAIL rsp_valid @%0t: even=%b odd=%b expected=%b", $time, e_valid, o_valid, m_phase == 2);
      end
      if (m_phase == 2) begin
        exp_e_cnt = 8'((exp_cnt > 255) ? 255 : exp_cnt);
        exp_o_cnt = 2'((exp_cnt > 3) ? 3 : exp_cnt);
        tests++;
        if (e_par !== exp_par || o_par !== ~exp_par) begin
          fails++;
          $display("FAIL rsp_parity @%0t: even=%b odd=%b expected even=%b odd=%b",
                   $time, e_par, o_par, exp_par, ~exp_par);
        end
        tests++;
        if (e_id !== 2'(m_grant) || o_id !== 2'(m_grant)) begin
          fails++;
          $display("FAIL rsp_id @%0t: even=%0d odd=%0d expected=%0d", $time, e_id, o_id, m_grant);
        end
        tests++;
        if (e_cnt !== exp_e_cnt || o_cnt !== exp_o_cnt) begin
          fails++;
          $display("FAIL rsp_count @%0t: even=%0d odd=%0d expected even=%0d odd=%0d",
                   $time, e_cnt, o_cnt, exp_e_cnt, exp_o_cnt);
        end
      end
      fire_id = -1;
      case (m_phase)
        0: if (req_valid != '0) begin
             m_grant = rr_model(req_valid, m_ptr);
             m_pkt.delete();
             m_phase = 1;
           end
        1: if (req_valid[m_grant]) begin
             fire_id = m_grant;
             m_pkt.push_back(req_data[32*m_grant +: 32]);
             if (req_last[m_grant]) begin
               exp_par       = pkt_parity();
               exp_cnt       = m_pkt.size();
               m_phase       = 2;
               m_resp_cycles = 0;
             end
           end
        default: if (rsp_ready) begin
             id_log.push_back(m_grant);
             m_ptr   = (m_grant + 1) % NREQ;
             m_phase = 0;
           end else begin
             m_resp_cycles++;
           end
      endcase
      @(posedge clk);
      #1;
      cyc++;
      if (fire_id >= 0) begin
        void'(q_data[fire_id].pop_front());
        void'(q_last[fire_id].pop_front());
        void'(q_gap[fire_id].pop_front());
      end
      apply_inputs();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1; req_last = '1; req_data = '1; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (e_ready !== '0 || o_ready !== '0 || e_valid !== 1'b0 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_handshake: ready e=%b o=%b valid e=%b o=%b expected all 0",
               e_ready, o_ready, e_valid, o_valid);
    end
    tests++;
    if (e_par !== 1'b0 || o_par !== 1'b0 || e_id !== '0 || o_id !== '0 || e_cnt !== '0 || o_cnt !== '0) begin
      fails++;
      $display("FAIL reset_fields: parity e=%b o=%b id e=%0d o=%0d count e=%0d o=%0d expected all 0",
               e_par, o_par, e_id, o_id, e_cnt, o_cnt);
    end
    req_valid = '0; req_last = '0; rsp_ready = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_word();
    rsp_mode = 0;
    add_word(0, 32'h0000_0007, 1'b1, 0);
    run_traffic(50, 0);
  endtask

  task automatic test_stall();
    rsp_mode = 0;
    add_word(2, 32'hFFFF_FFFF, 1'b0, 0);
    add_word(2, 32'h0000_0001, 1'b0, 2);
    add_word(2, 32'h0000_0003, 1'b1, 0);
    add_word(0, 32'h0000_0010, 1'b1, 1);
    run_traffic(100, 0);
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    rsp_mode = 0;
    add_word(0, 32'h0, 1'b1, 0);
    add_word(0, 32'h0, 1'b1, 0);
    for (int r = 1; r < NREQ; r++) add_word(r, 32'h0, 1'b1, 0);
    run_traffic(100, 0);
    tests++;
    if (id_log.size() != 5) begin
      fails++;
      $display("FAIL rr_count: got %0d responses expected 5", id_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests++;
        if (id_log[k] != exp_order[k]) begin
          fails++;
          $display("FAIL rr_order[%0d]: got %0d expected %0d", k, id_log[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_mode = 2;
    add_word(1, $urandom, 1'b0, 0);
    add_word(1, $urandom, 1'b1, 0);
    add_word(3, $urandom, 1'b1, 2);
    add_word(0, $urandom, 1'b1, 3);
    run_traffic(200, 0);
  endtask

  task automatic test_saturation();
    rsp_mode = 0;
    for (int k = 0; k < 6; k++) add_word(2, $urandom, (k == 5), 0);
    run_traffic(100, 0);
  endtask

  task automatic test_reset_mid_burst();
    rsp_mode = 0;
    for (int k = 0; k < 4; k++) add_word(3, $urandom, (k == 3), 0);
    run_traffic(100, 2);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (e_ready !== '0 || o_ready !== '0 || e_valid !== 1'b0 || o_valid !== 1'b0 ||
        e_par !== 1'b0 || o_par !== 1'b0 || e_id !== '0 || e_cnt !== '0 || o_cnt !== '0) begin
      fails++;
      $display("FAIL midburst_reset: ready e=%b o=%b valid e=%b o=%b par e=%b o=%b id=%0d cnt e=%0d o=%0d expected all 0",
               e_ready, o_ready, e_valid, o_valid, e_par, o_par, e_id, e_cnt, o_cnt);
    end
    model_reset();
    req_valid = '0; req_last = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) add_word(1, $urandom, (k == 2), 0);
    run_traffic(100, 0);
  endtask

  task automatic test_random();
    rsp_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int r   = $urandom_range(0, NREQ - 1);
      int len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) add_word(r, $urandom, (k == len - 1), $urandom_range(0, 2));
    end
    run_traffic(4000, 0);
  endtask

  initial begin
    rsp_mode = 0;
    test_reset();
    test_single_word();
    test_stall();
    test_round_robin();
    test_backpressure();
    test_saturation();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
